seq_arith_resp: RTL and testbench
=================================

Name: seq_arith_resp

Overview:
- Sequential arithmetic responder; serves as the target end of an operand request/response interface.
- Accepts one operand pair plus opcode per request on a valid/ready channel, computes either the sum (1 cycle) or the product (shift-and-add, WIDTH cycles), and returns the result on a valid/ready response channel.
- Sits behind any initiator that issues add/mult requests. Register-based, no multiplier inferred.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept request.
- req_op  input  1  0 = add, 1 = mult.
- req_a  input  WIDTH  operand a, unsigned.
- req_b  input  WIDTH  operand b, unsigned (multiplier for mult).
- rsp_valid  output  1  result present.
- rsp_ready  input  1  initiator accepts result.
- rsp_data  output  2*WIDTH  result, unsigned.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  number of completed response handshakes, wrapping.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset: asserting rst_n low at any time, including mid-operation, immediately forces state=IDLE and all internal registers to 0.
  - Reset values: req_ready=1 once IDLE (0 while rst_n low), rsp_valid=0, rsp_data=0, busy=0, op_count=0.
  - Any in-flight operation is discarded; no response is produced for it.
- States: IDLE, MUL, DONE.
- IDLE:
  - req_ready=1.
  - Request handshake = req_valid && req_ready at a rising edge; req_a/req_b/req_op are captured on that edge.
  - op=0: sum {1'b0,a}+{1'b0,b} is zero-extended to 2*WIDTH into rsp_data; next state DONE. Response is visible the cycle after the handshake (latency 1).
  - op=1: clear accumulator, load multiplicand (2*WIDTH, zero-extended) and multiplier, set bit counter=WIDTH-1; next state MUL.
- MUL:
  - req_ready=0; req_valid is ignored and no capture occurs.
  - Each edge: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - On the edge where counter==0 (the WIDTH-th MUL edge), the final acc is written to rsp_data and state becomes DONE.
  - rsp_valid rises exactly WIDTH+1 edges after the request handshake edge.
  - No early termination on zero operands; latency is fixed.
- DONE:
  - rsp_valid=1, req_ready=0.
  - rsp_data is stable while rsp_valid && !rsp_ready, with no upper bound on the stall.
  - On an edge with rsp_ready=1: state IDLE, rsp_valid=0, op_count += 1 (wraps from 2**CNT_W-1 to 0).
  - No new request is accepted on that same edge; the earliest next request handshake is one cycle later.
- rsp_data retains its last value in IDLE; consumers must sample it only when rsp_valid=1.
- Arithmetic: all unsigned. Add result is at most 2^(WIDTH+1)-2; mult result is at most (2^WIDTH-1)^2, so 2*WIDTH bits is exact and never overflows.
- Counter width is derived by a constant function: ceil(log2(WIDTH)), minimum 1.
- X-safety: when req_valid=0, req_op/req_a/req_b are don't-care and must not affect state.

Test Plan (WIDTH=8):
- Mult max: a=255, b=255, op=1, rsp_ready=1 → rsp_valid rises exactly 9 edges after handshake edge, rsp_data=16'hFE01, op_count=1, req_ready high again the cycle after the response handshake.
- Add carry: a=255, b=255, op=0 → rsp_valid the cycle after handshake, rsp_data=16'h01FE; then a=0, b=0 → rsp_data=0, op_count=2.
- Backpressure: mult 13×11, hold rsp_ready=0 for 6 cycles after rsp_valid → rsp_data=16'h008F stable and rsp_valid high throughout; op_count increments only on the release edge.
- Request while busy: during MUL, toggle req_valid with a=1, b=1 → req_ready=0, no capture, result of original 200×3=16'h0258 unaffected.
- Reset mid-op: assert rst_n low 4 edges into a 255×255 mult → asynchronously rsp_valid=0, busy=0, op_count=0. After release, a new 2×3 mult → 16'h0006 with normal latency.
- Zero/one operands: 0×200 → 16'h0000 and 1×200 → 16'h00C8, both with full 9-edge latency.

Source files
------------

// File: rtl/seq_arith_resp.sv
// seq_arith_resp: valid/ready arithmetic responder, 1-cycle add or WIDTH-cycle shift-and-add multiply.
module seq_arith_resp #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);
    function automatic int cnt_bits(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int BW = cnt_bits(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state, next_state;
    logic [2*WIDTH-1:0] acc, mcand, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [BW-1:0]      bit_cnt;
    logic               req_fire, last_bit;

    assign req_fire = req_valid && req_ready;
    assign last_bit = (bit_cnt == '0);
    assign acc_next = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = (state == IDLE && req_fire)     ? (req_op ? MUL : DONE) :
                     (state == MUL && last_bit)      ? DONE :
                     (state == DONE && rsp_ready)    ? IDLE : state;
    end

    always_comb begin
        req_ready = rst_n && (state == IDLE);
        rsp_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operands are only touched on a real handshake, so idle don't-care inputs never leak into state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            bit_cnt  <= '0;
            rsp_data <= '0;
            op_count <= '0;
        end else begin
            if (state == IDLE && req_fire) begin
                if (req_op) begin
                    acc     <= '0;
                    mcand   <= {{WIDTH{1'b0}}, req_a};
                    mplier  <= req_b;
                    bit_cnt <= BW'(WIDTH - 1);
                end else begin
                    rsp_data <= {{(WIDTH-1){1'b0}}, {1'b0, req_a} + {1'b0, req_b}};
                end
            end
            if (state == MUL) begin
                acc     <= acc_next;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                bit_cnt <= bit_cnt - 1'b1;
                if (last_bit) rsp_data <= acc_next;
            end
            if (state == DONE && rsp_ready) op_count <= op_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_arith_resp.sv
// tb_seq_arith_resp: directed scoreboard bench for seq_arith_resp (WIDTH=8).
module tb_seq_arith_resp;
    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic               clk = 0;
    logic               rst_n = 0;
    logic               req_valid = 0;
    logic               req_ready;
    logic               req_op = 0;
    logic [WIDTH-1:0]   req_a = 0;
    logic [WIDTH-1:0]   req_b = 0;
    logic               rsp_valid;
    logic               rsp_ready = 0;
    logic [2*WIDTH-1:0] rsp_data;
    logic               busy;
    logic [CNT_W-1:0]   op_count;

    seq_arith_resp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [2*WIDTH-1:0] exp_q[$];
    int exp_lat_q[$];
    int hs_cyc;
    logic [CNT_W-1:0] exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at #1 after the handshake edge with req_valid dropped.
    task automatic start_req(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 1);
        req_valid = 1; req_op = op; req_a = a; req_b = b;
        exp_q.push_back(op ? 16'(a) * 16'(b) : 16'(a) + 16'(b));
        exp_lat_q.push_back(op ? WIDTH + 1 : 1);
        @(posedge clk); #1;
        hs_cyc = cyc;
        req_valid = 0; req_op = 1'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        chk("busy_after_hs", {31'b0, busy}, 1);
    endtask

    task automatic finish_rsp(input int stall);
        int n;
        logic [2*WIDTH-1:0] exp_d;
        n = 0;
        rsp_ready = (stall == 0);
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        exp_d = exp_q.pop_front();
        chk("rsp_latency", cyc - hs_cyc + 1, exp_lat_q.pop_front());
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, exp_d});
        chk("req_ready_in_done", {31'b0, req_ready}, 0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'b0, rsp_valid}, 1);
            chk("stall_data", {16'b0, rsp_data}, {16'b0, exp_d});
            chk("stall_count", {16'b0, op_count}, {16'b0, exp_cnt});
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        exp_cnt++;
        chk("count_after_rsp", {16'b0, op_count}, {16'b0, exp_cnt});
        chk("valid_after_rsp", {31'b0, rsp_valid}, 0);
        chk("ready_after_rsp", {31'b0, req_ready}, 1);
    endtask

    initial begin
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_op_count", {16'b0, op_count}, 0);
        chk("rst_rsp_data", {16'b0, rsp_data}, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        chk("idle_req_ready", {31'b0, req_ready}, 1);
        // Idle inputs with req_valid low must not disturb anything.
        for (int i = 0; i < 3; i++) begin
            req_op = 1'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
            @(posedge clk); #1;
            chk("idle_no_capture", {31'b0, busy}, 0);
        end
        start_req(1, 255, 255); finish_rsp(0);
        start_req(0, 255, 255); finish_rsp(0);
        start_req(0, 0, 0);     finish_rsp(0);
        chk("count_two_adds", {16'b0, op_count}, 3);
        start_req(1, 13, 11);   finish_rsp(6);
        start_req(1, 200, 3);
        for (int i = 0; i < 4; i++) begin
            req_valid = i[0]; req_op = 0; req_a = 1; req_b = 1;
            @(posedge clk); #1;
            chk("busy_req_ready", {31'b0, req_ready}, 0);
        end
        req_valid = 0;
        finish_rsp(0);
        start_req(1, 255, 255);
        repeat (3) @(posedge clk);
        #3; rst_n = 0; #1;
        chk("arst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_op_count", {16'b0, op_count}, 0);
        chk("arst_req_ready", {31'b0, req_ready}, 0);
        exp_q.delete(); exp_lat_q.delete(); exp_cnt = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        start_req(1, 2, 3);   finish_rsp(0);
        start_req(1, 0, 200); finish_rsp(0);
        start_req(1, 1, 200); finish_rsp(2);
        chk("final_count", {16'b0, op_count}, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
